// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width and the probe sequencer states.
package audio_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      BURST,
      COOLDOWN
   } probe_state_t;

endpackage

// File: rtl/burst_envelope.sv
// Combinational sample shaper: maps burst index k and tone polarity to a signed sample.
module burst_envelope
   import audio_pkg::*;
#(
   parameter int unsigned                BURST_LEN = 16,
   parameter logic signed [SAMPLE_W-1:0] AMPLITUDE = 16'sd24000,
   parameter int unsigned                RAMP_LOG2 = 2,
   parameter int unsigned                KW        = $clog2(BURST_LEN) + 1
) (
   input  logic [KW-1:0]              k,
   input  logic                       neg,
   output logic signed [SAMPLE_W-1:0] sample
);

   localparam int unsigned PW = SAMPLE_W + RAMP_LOG2 + 1;
   localparam int unsigned EW = RAMP_LOG2 + 1;

   logic [31:0]         rise;
   logic [31:0]         fall;
   logic [31:0]         env32;
   logic [EW-1:0]       env;
   logic [PW-1:0]       prod;
   logic [SAMPLE_W-1:0] mag;

   // env = min(k+1, BURST_LEN-k, 2**RAMP_LOG2); the product is wide enough that nothing clips
   always_comb begin
      rise  = 32'(k) + 32'd1;
      fall  = BURST_LEN - 32'(k);
      env32 = 32'd1 << RAMP_LOG2;
      if (rise < env32) env32 = rise;
      if (fall < env32) env32 = fall;
      env    = EW'(env32);
      prod   = PW'(AMPLITUDE) * PW'(env);
      mag    = SAMPLE_W'(prod >> RAMP_LOG2);
      sample = neg ? -$signed(mag) : $signed(mag);
   end

endmodule

// File: rtl/probe_burst_generator.sv
// Ranging probe source: a trigger yields one envelope-shaped tone burst on the sample grid,
// marked by impulse_out, followed by a silent guard interval.
module probe_burst_generator
   import audio_pkg::*;
#(
   parameter int unsigned                BURST_LEN   = 16,
   parameter int unsigned                HALF_PERIOD = 2,
   parameter logic signed [SAMPLE_W-1:0] AMPLITUDE   = 16'sd24000,
   parameter int unsigned                RAMP_LOG2   = 2,
   parameter int unsigned                GUARD_LEN   = 64
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       step_in,
   input  logic                       impulse_in,
   output logic signed [SAMPLE_W-1:0] amp_out,
   output logic                       impulse_out,
   output logic                       busy,
   output logic                       burst_done,
   output logic                       trig_dropped
);

   localparam int unsigned KW  = $clog2(BURST_LEN) + 1;
   localparam int unsigned GW  = $clog2(GUARD_LEN) + 1;
   localparam int unsigned PHW = $clog2(HALF_PERIOD + 1);

   probe_state_t                state_q, state_d;
   logic [KW-1:0]               k_q, k_d;
   logic [PHW-1:0]              phase_q, phase_d;
   logic                        neg_q, neg_d;
   logic [GW-1:0]               guard_q, guard_d;
   logic signed [SAMPLE_W-1:0]  amp_q, amp_d;
   logic                        impulse_q, impulse_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        dropped_q, dropped_d;
   logic signed [SAMPLE_W-1:0]  env_sample;

   burst_envelope #(
      .BURST_LEN (BURST_LEN),
      .AMPLITUDE (AMPLITUDE),
      .RAMP_LOG2 (RAMP_LOG2),
      .KW        (KW)
   ) u_envelope (
      .k      (k_q),
      .neg    (neg_q),
      .sample (env_sample)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      phase_d   = phase_q;
      neg_d     = neg_q;
      guard_d   = guard_q;
      amp_d     = amp_q;
      impulse_d = 1'b0;
      done_d    = 1'b0;
      dropped_d = impulse_in && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            k_d     = '0;
            phase_d = '0;
            neg_d   = 1'b0;
            guard_d = '0;
            amp_d   = '0;
            if (impulse_in) state_d = ARMED;
         end
         ARMED, BURST: begin
            if (step_in) begin
               if (k_q == KW'(BURST_LEN)) begin
                  amp_d   = '0;
                  done_d  = 1'b1;
                  guard_d = '0;
                  state_d = COOLDOWN;
               end else begin
                  amp_d     = env_sample;
                  impulse_d = (state_q == ARMED);
                  state_d   = BURST;
                  k_d       = k_q + KW'(1);
                  // Polarity flips every HALF_PERIOD samples without dividing k
                  if (phase_q == PHW'(HALF_PERIOD - 1)) begin
                     phase_d = '0;
                     neg_d   = ~neg_q;
                  end else begin
                     phase_d = phase_q + PHW'(1);
                  end
               end
            end
         end
         COOLDOWN: begin
            if (step_in) begin
               guard_d = guard_q + GW'(1);
               if (guard_q == GW'(GUARD_LEN - 1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         k_q       <= '0;
         phase_q   <= '0;
         neg_q     <= 1'b0;
         guard_q   <= '0;
         amp_q     <= '0;
         impulse_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         phase_q   <= phase_d;
         neg_q     <= neg_d;
         guard_q   <= guard_d;
         amp_q     <= amp_d;
         impulse_q <= impulse_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dropped_q <= dropped_d;
      end
   end

   assign amp_out      = amp_q;
   assign impulse_out  = impulse_q;
   assign busy         = busy_q;
   assign burst_done   = done_q;
   assign trig_dropped = dropped_q;

endmodule
